// File: rtl/estimador_vadd_pkg.sv
// Shared definitions for the estimator's 3-element vector-add loop:
// element width, initiator state encoding and saturation limits.
package estimador_vadd_pkg;

    localparam int W               = 21;
    localparam int DEFAULT_TIMEOUT = 15;

    localparam logic [W-1:0] VADD_SAT_MAX = 21'h0FFFFF;
    localparam logic [W-1:0] VADD_SAT_MIN = 21'h100000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } vadd_init_state_t;

endpackage

// File: rtl/estimador_func_vadd_row_initiator.sv
// Initiator for the vadd_row child (ap_ctrl_hs): registers an operand pair,
// runs the child under a watchdog and holds the result vector until taken.
module estimador_func_vadd_row_initiator #(
    parameter int W       = estimador_vadd_pkg::W,
    parameter int TIMEOUT = estimador_vadd_pkg::DEFAULT_TIMEOUT
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a0,
    input  logic [W-1:0] in_a1,
    input  logic [W-1:0] in_a2,
    input  logic [W-1:0] in_b0,
    input  logic [W-1:0] in_b1,
    input  logic [W-1:0] in_b2,

    output logic         child_ap_start,
    input  logic         child_ap_done,
    input  logic         child_ap_idle,
    input  logic         child_ap_ready,
    output logic [W-1:0] child_lhs0,
    output logic [W-1:0] child_lhs1,
    output logic [W-1:0] child_lhs2,
    output logic [W-1:0] child_rhs0,
    output logic [W-1:0] child_rhs1,
    output logic [W-1:0] child_rhs2,
    input  logic [W-1:0] child_out0,
    input  logic [W-1:0] child_out1,
    input  logic [W-1:0] child_out2,
    input  logic         child_vld0,
    input  logic         child_vld1,
    input  logic         child_vld2,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_r0,
    output logic [W-1:0] out_r1,
    output logic [W-1:0] out_r2,
    output logic         out_err
);

    import estimador_vadd_pkg::*;

    localparam int WD = $clog2(TIMEOUT + 1);

    vadd_init_state_t r_state;
    logic             r_in_ready;
    logic             r_start;
    logic             r_out_valid;
    logic             r_err;
    logic [2:0]       r_cap;
    logic [WD-1:0]    r_wdog;
    logic [W-1:0]     r_lhs [3];
    logic [W-1:0]     r_rhs [3];
    logic [W-1:0]     r_res [3];

    logic [2:0]       w_vld;
    logic [W-1:0]     w_cout [3];
    logic             w_unused_idle;

    assign w_vld     = {child_vld2, child_vld1, child_vld0};
    assign w_cout[0] = child_out0;
    assign w_cout[1] = child_out1;
    assign w_cout[2] = child_out2;

    // The child's idle flag carries no information this controller needs.
    assign w_unused_idle = child_ap_idle;

    // Done takes priority over watchdog expiry, so a child finishing on the
    // last permitted cycle still delivers its results with an honest err.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_start     <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_cap       <= '0;
            r_wdog      <= '0;
            r_lhs       <= '{default: '0};
            r_rhs       <= '{default: '0};
            r_res       <= '{default: '0};
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_lhs      <= '{in_a0, in_a1, in_a2};
                        r_rhs      <= '{in_b0, in_b1, in_b2};
                        r_cap      <= '0;
                        r_wdog     <= '0;
                        r_start    <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < 3; k++) begin
                        if (w_vld[k]) begin
                            r_res[k] <= w_cout[k];
                        end
                    end
                    r_cap  <= r_cap | w_vld;
                    r_wdog <= r_wdog + 1'b1;
                    if (child_ap_ready) begin
                        r_start <= 1'b0;
                    end
                    if (child_ap_done) begin
                        r_err       <= ~&(r_cap | w_vld);
                        r_start     <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else if (r_wdog == WD'(TIMEOUT - 1)) begin
                        r_res       <= '{default: '0};
                        r_err       <= 1'b1;
                        r_start     <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_err       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready       = r_in_ready;
    assign child_ap_start = r_start;
    assign child_lhs0     = r_lhs[0];
    assign child_lhs1     = r_lhs[1];
    assign child_lhs2     = r_lhs[2];
    assign child_rhs0     = r_rhs[0];
    assign child_rhs1     = r_rhs[1];
    assign child_rhs2     = r_rhs[2];
    assign out_valid      = r_out_valid;
    assign out_r0         = r_res[0];
    assign out_r1         = r_res[1];
    assign out_r2         = r_res[2];
    assign out_err        = r_err;

endmodule

// File: tb/tb_estimador_func_vadd_row_initiator.sv
// Directed bench for the vadd_row initiator with a behavioural child that
// can finish normally, finish late, drop a valid, or hang.
module tb_estimador_func_vadd_row_initiator;

    import estimador_vadd_pkg::VADD_SAT_MAX;
    import estimador_vadd_pkg::VADD_SAT_MIN;

    localparam int W       = 21;
    localparam int TIMEOUT = 15;

    localparam int M_NORMAL = 0;
    localparam int M_MISSV  = 1;
    localparam int M_HUNG   = 2;

    logic         ap_clk   = 1'b0;
    logic         ap_rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a0 = '0, in_a1 = '0, in_a2 = '0;
    logic [W-1:0] in_b0 = '0, in_b1 = '0, in_b2 = '0;
    logic         child_ap_start;
    logic         child_ap_done  = 1'b0;
    logic         child_ap_idle  = 1'b1;
    logic         child_ap_ready = 1'b0;
    logic [W-1:0] child_lhs0, child_lhs1, child_lhs2;
    logic [W-1:0] child_rhs0, child_rhs1, child_rhs2;
    logic [W-1:0] child_out0 = '0, child_out1 = '0, child_out2 = '0;
    logic         child_vld0 = 1'b0, child_vld1 = 1'b0, child_vld2 = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_r0, out_r1, out_r2;
    logic         out_err;

    int nAssert = 0;
    int nFail   = 0;
    int mode    = M_NORMAL;
    int doneAt  = 4;
    int cnt     = 0;
    bit busy    = 1'b0;

    estimador_func_vadd_row_initiator #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a0          (in_a0),
        .in_a1          (in_a1),
        .in_a2          (in_a2),
        .in_b0          (in_b0),
        .in_b1          (in_b1),
        .in_b2          (in_b2),
        .child_ap_start (child_ap_start),
        .child_ap_done  (child_ap_done),
        .child_ap_idle  (child_ap_idle),
        .child_ap_ready (child_ap_ready),
        .child_lhs0     (child_lhs0),
        .child_lhs1     (child_lhs1),
        .child_lhs2     (child_lhs2),
        .child_rhs0     (child_rhs0),
        .child_rhs1     (child_rhs1),
        .child_rhs2     (child_rhs2),
        .child_out0     (child_out0),
        .child_out1     (child_out1),
        .child_out2     (child_out2),
        .child_vld0     (child_vld0),
        .child_vld1     (child_vld1),
        .child_vld2     (child_vld2),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_r0         (out_r0),
        .out_r1         (out_r1),
        .out_r2         (out_r2),
        .out_err        (out_err)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic logic [W-1:0] satAdd(input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
        s = $signed(a) + $signed(b);
        if (s > 1048575)  return VADD_SAT_MAX;
        if (s < -1048576) return VADD_SAT_MIN;
        return s[W-1:0];
    endfunction

    // Child model: ready on its first cycle, done plus valids on cycle doneAt.
    always @(negedge ap_clk) begin
        child_ap_done  = 1'b0;
        child_ap_ready = 1'b0;
        child_vld0     = 1'b0;
        child_vld1     = 1'b0;
        child_vld2     = 1'b0;
        if (!ap_rst_n) begin
            busy = 1'b0;
            cnt  = 0;
        end else if (mode != M_HUNG) begin
            if (!busy && child_ap_start) begin
                busy           = 1'b1;
                cnt            = 1;
                child_ap_ready = 1'b1;
            end else if (busy) begin
                cnt++;
            end
            if (busy && cnt == doneAt) begin
                child_ap_done = 1'b1;
                child_out0    = satAdd(child_lhs0, child_rhs0);
                child_out1    = satAdd(child_lhs1, child_rhs1);
                child_out2    = satAdd(child_lhs2, child_rhs2);
                child_vld0    = 1'b1;
                child_vld1    = (mode != M_MISSV);
                child_vld2    = 1'b1;
                busy          = 1'b0;
            end
        end
        child_ap_idle = !busy;
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [W-1:0] a2,
                                 input logic [W-1:0] b0, input logic [W-1:0] b1, input logic [W-1:0] b2);
        in_a0    = a0;
        in_a1    = a1;
        in_a2    = a2;
        in_b0    = b0;
        in_b1    = b1;
        in_b2    = b2;
        in_valid = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #12;
        checkOutput("rst_in_ready", W'(in_ready), W'(1));
        checkOutput("rst_start", W'(child_ap_start), W'(0));
        checkOutput("rst_out_valid", W'(out_valid), W'(0));
        checkOutput("rst_err", W'(out_err), W'(0));
        checkOutput("rst_r0", out_r0, '0);
        checkOutput("rst_lhs0", child_lhs0, '0);
        checkOutput("rst_rhs2", child_rhs2, '0);
        checkOutput("rst_child_idle", W'(child_ap_idle), W'(1));
        ap_rst_n = 1'b1;
        tick();

        // Basic vector, 5-cycle latency
        applyStimulus(21'd1, 21'd2, 21'd3, 21'd10, 21'd20, 21'd30);
        tick();
        in_valid = 1'b0;
        checkOutput("basic_c1_start", W'(child_ap_start), W'(1));
        checkOutput("basic_c1_in_ready", W'(in_ready), W'(0));
        checkOutput("basic_c1_lhs0", child_lhs0, 21'd1);
        checkOutput("basic_c1_rhs2", child_rhs2, 21'd30);
        tick();
        checkOutput("basic_c2_start", W'(child_ap_start), W'(0));
        repeat (2) tick();
        checkOutput("basic_c4_out_valid", W'(out_valid), W'(0));
        tick();
        checkOutput("basic_c5_out_valid", W'(out_valid), W'(1));
        checkOutput("basic_r0", out_r0, 21'd11);
        checkOutput("basic_r1", out_r1, 21'd22);
        checkOutput("basic_r2", out_r2, 21'd33);
        checkOutput("basic_err", W'(out_err), W'(0));
        tick();
        checkOutput("basic_c6_in_ready", W'(in_ready), W'(1));
        checkOutput("basic_c6_out_valid", W'(out_valid), W'(0));

        // Saturated results pass through unchanged
        applyStimulus(21'h0FFFFF, 21'h100000, 21'h1FFFFB, 21'h000001, 21'h1FFFFF, 21'h000005);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checkOutput("sat_out_valid", W'(out_valid), W'(1));
        checkOutput("sat_r0", out_r0, 21'h0FFFFF);
        checkOutput("sat_r1", out_r1, 21'h100000);
        checkOutput("sat_r2", out_r2, 21'h000000);
        checkOutput("sat_err", W'(out_err), W'(0));
        tick();

        // Back-pressure: HOLD persists, new operands wait
        out_ready = 1'b0;
        applyStimulus(21'd100, 21'd200, 21'd300, 21'd1, 21'd2, 21'd3);
        tick();
        applyStimulus(21'd7, 21'd7, 21'd7, 21'd1, 21'd1, 21'd1);
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_out_valid", W'(out_valid), W'(1));
            checkOutput("bp_in_ready", W'(in_ready), W'(0));
            checkOutput("bp_r0", out_r0, 21'd101);
            checkOutput("bp_r2", out_r2, 21'd303);
            checkOutput("bp_lhs0", child_lhs0, 21'd100);
            tick();
        end
        out_ready = 1'b1;
        tick();
        checkOutput("bp_idle_in_ready", W'(in_ready), W'(1));
        checkOutput("bp_idle_out_valid", W'(out_valid), W'(0));
        checkOutput("bp_idle_lhs0", child_lhs0, 21'd100);
        tick();
        in_valid = 1'b0;
        checkOutput("bp_next_lhs0", child_lhs0, 21'd7);
        checkOutput("bp_next_start", W'(child_ap_start), W'(1));
        repeat (4) tick();
        checkOutput("bp_next_out_valid", W'(out_valid), W'(1));
        checkOutput("bp_next_r1", out_r1, 21'd8);
        tick();

        // Hung child: watchdog aborts after TIMEOUT RUN cycles
        mode = M_HUNG;
        applyStimulus(21'd9, 21'd9, 21'd9, 21'd9, 21'd9, 21'd9);
        tick();
        in_valid = 1'b0;
        repeat (TIMEOUT - 1) tick();
        checkOutput("hung_c15_start", W'(child_ap_start), W'(1));
        checkOutput("hung_c15_out_valid", W'(out_valid), W'(0));
        tick();
        checkOutput("hung_start_drop", W'(child_ap_start), W'(0));
        checkOutput("hung_out_valid", W'(out_valid), W'(1));
        checkOutput("hung_r0", out_r0, '0);
        checkOutput("hung_r1", out_r1, '0);
        checkOutput("hung_r2", out_r2, '0);
        checkOutput("hung_err", W'(out_err), W'(1));
        tick();
        mode = M_NORMAL;

        // Done on the same cycle the watchdog expires: done wins
        doneAt = TIMEOUT;
        applyStimulus(21'd30, 21'd40, 21'd50, 21'd3, 21'd4, 21'd5);
        tick();
        in_valid = 1'b0;
        repeat (TIMEOUT - 1) tick();
        checkOutput("late_c15_out_valid", W'(out_valid), W'(0));
        tick();
        checkOutput("late_out_valid", W'(out_valid), W'(1));
        checkOutput("late_err", W'(out_err), W'(0));
        checkOutput("late_r0", out_r0, 21'd33);
        checkOutput("late_r2", out_r2, 21'd55);
        tick();
        doneAt = 4;

        // Missing valid on element 1
        mode = M_MISSV;
        applyStimulus(21'd4, 21'd5, 21'd6, 21'd1, 21'd1, 21'd1);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checkOutput("missv_out_valid", W'(out_valid), W'(1));
        checkOutput("missv_err", W'(out_err), W'(1));
        checkOutput("missv_r0", out_r0, 21'd5);
        checkOutput("missv_r2", out_r2, 21'd7);
        tick();
        mode = M_NORMAL;

        // Reset in the middle of a run, then a fresh vector
        applyStimulus(21'd1, 21'd1, 21'd1, 21'd1, 21'd1, 21'd1);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        ap_rst_n = 1'b0;
        #1;
        checkOutput("mrst_start", W'(child_ap_start), W'(0));
        checkOutput("mrst_out_valid", W'(out_valid), W'(0));
        checkOutput("mrst_in_ready", W'(in_ready), W'(1));
        checkOutput("mrst_lhs0", child_lhs0, '0);
        checkOutput("mrst_r0", out_r0, '0);
        tick();
        ap_rst_n = 1'b1;
        applyStimulus(21'd2, 21'd3, 21'd4, 21'd5, 21'd6, 21'd7);
        tick();
        in_valid = 1'b0;
        checkOutput("fresh_c1_start", W'(child_ap_start), W'(1));
        repeat (3) tick();
        checkOutput("fresh_c4_out_valid", W'(out_valid), W'(0));
        tick();
        checkOutput("fresh_out_valid", W'(out_valid), W'(1));
        checkOutput("fresh_r0", out_r0, 21'd7);
        checkOutput("fresh_r1", out_r1, 21'd9);
        checkOutput("fresh_r2", out_r2, 21'd11);
        checkOutput("fresh_err", W'(out_err), W'(0));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
